// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared definitions for the two-master AHB-style bus arbiter: owner encoding,
// transfer-type constants and default widths.
package ahb_bus_arbiter_pkg;

    localparam int unsigned AW_DEF = 32;
    localparam int unsigned DW_DEF = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic HTRANS_IDLE   = 1'b0;
    localparam logic HTRANS_NONSEQ = 1'b1;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

endpackage

// File: rtl/ahb_bus_arbiter_starve_ctr.sv
// Saturating count of consecutive M0 grants taken while M1 is waiting.
// sat_c reflects the value being loaded this cycle so arbitration reacts immediately.
module bus_arb_starve_ctr
    import ahb_bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_CNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic inc,
    output logic sat_c
);

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CNT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (clr) begin
                cnt_d = '0;
            end else if (inc && (cnt_q != MAX_V)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign sat_c = (cnt_d == MAX_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Two-master bus arbiter: fixed priority to M0 with starvation cap for M1,
// bus lock for read-modify-write pairs, pipelined address/data phases.
module ahb_bus_arbiter
    import ahb_bus_arbiter_pkg::*;
#(
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned MAX_DBURST = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          m0_htrans,
    input  logic [AW-1:0] m0_haddr,
    input  logic          m0_hwrite,
    input  logic [DW-1:0] m0_hwdata,
    input  logic          m0_hlock,
    output logic          m0_grant,
    output logic          m0_rvalid,
    input  logic          m1_htrans,
    input  logic [AW-1:0] m1_haddr,
    input  logic          m1_hwrite,
    input  logic [DW-1:0] m1_hwdata,
    input  logic          m1_hlock,
    output logic          m1_grant,
    output logic          m1_rvalid,
    output logic [DW-1:0] m_hrdata,
    output logic          s_htrans,
    output logic [AW-1:0] s_haddr,
    output logic          s_hwrite,
    output logic [DW-1:0] s_hwdata,
    input  logic [DW-1:0] s_hrdata,
    input  logic          s_hready,
    output logic [1:0]    owner
);

    owner_e state_q, state_d;
    logic   lock_q, lock_d;
    logic   dp_valid_q, dp_valid_d;
    logic   dp_m1_q, dp_m1_d;
    logic   dp_write_q, dp_write_d;
    logic   starve_sat_c;

    bus_arb_starve_ctr #(
        .MAX_CNT (MAX_DBURST)
    ) u_starve (
        .clk   (CLK),
        .rst   (RESET),
        .en    (s_hready),
        .clr   (m1_grant | ~m1_htrans),
        .inc   (m0_grant & m1_htrans),
        .sat_c (starve_sat_c)
    );

    // Address phase: owner's request drives the slave directly.
    always_comb begin
        s_htrans = HTRANS_IDLE;
        s_haddr  = '0;
        s_hwrite = 1'b0;
        m0_grant = 1'b0;
        m1_grant = 1'b0;
        unique case (state_q)
            OWN_M0: begin
                s_htrans = m0_htrans;
                s_haddr  = m0_haddr;
                s_hwrite = m0_hwrite;
                m0_grant = (m0_htrans == HTRANS_NONSEQ) & s_hready;
            end
            OWN_M1: begin
                s_htrans = m1_htrans;
                s_haddr  = m1_haddr;
                s_hwrite = m1_hwrite;
                m1_grant = (m1_htrans == HTRANS_NONSEQ) & s_hready;
            end
            default: ;
        endcase
    end

    // Arbitration, lock and data-phase tracking; everything holds while s_hready is low.
    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        dp_valid_d = dp_valid_q;
        dp_m1_d    = dp_m1_q;
        dp_write_d = dp_write_q;
        if (s_hready) begin
            if (m0_grant) begin
                lock_d = m0_hlock;
            end else if (m1_grant) begin
                lock_d = m1_hlock;
            end

            // The lock just sampled wins even over a saturated starvation count.
            if (lock_d) begin
                state_d = state_q;
            end else if (m0_htrans && !(m1_htrans && starve_sat_c)) begin
                state_d = OWN_M0;
            end else if (m1_htrans) begin
                state_d = OWN_M1;
            end else begin
                state_d = OWN_IDLE;
            end

            dp_valid_d = m0_grant | m1_grant;
            if (m0_grant | m1_grant) begin
                dp_m1_d    = m1_grant;
                dp_write_d = s_hwrite;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= OWN_IDLE;
            lock_q     <= 1'b0;
            dp_valid_q <= 1'b0;
            dp_m1_q    <= 1'b0;
            dp_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            dp_valid_q <= dp_valid_d;
            dp_m1_q    <= dp_m1_d;
            dp_write_q <= dp_write_d;
        end
    end

    assign s_hwdata  = (dp_valid_q && dp_write_q) ? (dp_m1_q ? m1_hwdata : m0_hwdata) : '0;
    assign m0_rvalid = dp_valid_q & ~dp_m1_q & s_hready;
    assign m1_rvalid = dp_valid_q & dp_m1_q & s_hready;
    assign m_hrdata  = s_hrdata;
    assign owner     = state_q;

endmodule
